// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle RV32I core.
// Decodes op/funct3/funct7_5 from the instruction register and sequences the
// datapath (PC, IR/OldPC, ALU, register file, shared memory). Memory accesses
// stall on a ready handshake and trap after MEM_TIMEOUT wait cycles. Illegal
// encodings also trap. TRAP is held until reset.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   op, funct3, funct7_5 instruction fields from the IR
//   zero                ALU result-is-zero flag
//   mem_ready           memory completes the current access this cycle
//   pc_write, ir_write  PC / IR+OldPC load enables
//   adr_src             memory address select (0 = PC, 1 = Result)
//   mem_req, mem_we     memory request / write enable
//   mem_size            00 byte, 01 half, 10 word
//   mem_unsigned        zero-extend loaded data
//   result_src          00 ALUOut, 01 Data, 10 ALUResult
//   alu_control         ALU operation code
//   alu_src_a/b, imm_src ALU operand and immediate selects
//   reg_write           register file write enable
//   illegal_instr       sticky illegal-instruction flag
//   mem_timeout         sticky memory-timeout flag
//   state_o             current state encoding (debug)
module multicycle_ctrl #(
    parameter int unsigned ALU_CTRL_W  = 4,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic                  funct7_5,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  adr_src,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  ir_write,
    output logic [1:0]            result_src,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [2:0]            imm_src,
    output logic                  reg_write,
    output logic [1:0]            mem_size,
    output logic                  mem_unsigned,
    output logic                  illegal_instr,
    output logic                  mem_timeout,
    output logic [3:0]            state_o
);

    typedef enum logic [3:0] {
        StReset    = 4'd0,
        StFetch    = 4'd1,
        StDecode   = 4'd2,
        StMemAdr   = 4'd3,
        StMemRead  = 4'd4,
        StMemWb    = 4'd5,
        StMemWrite = 4'd6,
        StExecR    = 4'd7,
        StExecI    = 4'd8,
        StAluWb    = 4'd9,
        StBranch   = 4'd10,
        StJal      = 4'd11,
        StJalr     = 4'd12,
        StLui      = 4'd13,
        StTrap     = 4'd14
    } state_e;

    localparam logic [6:0] OpLoad   = 7'd3;
    localparam logic [6:0] OpStore  = 7'd35;
    localparam logic [6:0] OpR      = 7'd51;
    localparam logic [6:0] OpI      = 7'd19;
    localparam logic [6:0] OpBranch = 7'd99;
    localparam logic [6:0] OpJal    = 7'd111;
    localparam logic [6:0] OpJalr   = 7'd103;
    localparam logic [6:0] OpLui    = 7'd55;
    localparam logic [6:0] OpAuipc  = 7'd23;

    localparam logic [ALU_CTRL_W-1:0] AluAdd  = ALU_CTRL_W'(0);
    localparam logic [ALU_CTRL_W-1:0] AluSub  = ALU_CTRL_W'(1);
    localparam logic [ALU_CTRL_W-1:0] AluAnd  = ALU_CTRL_W'(2);
    localparam logic [ALU_CTRL_W-1:0] AluOr   = ALU_CTRL_W'(3);
    localparam logic [ALU_CTRL_W-1:0] AluXor  = ALU_CTRL_W'(4);
    localparam logic [ALU_CTRL_W-1:0] AluSlt  = ALU_CTRL_W'(5);
    localparam logic [ALU_CTRL_W-1:0] AluSltu = ALU_CTRL_W'(6);
    localparam logic [ALU_CTRL_W-1:0] AluSll  = ALU_CTRL_W'(7);
    localparam logic [ALU_CTRL_W-1:0] AluSrl  = ALU_CTRL_W'(8);
    localparam logic [ALU_CTRL_W-1:0] AluSra  = ALU_CTRL_W'(9);

    // Counter only ever holds 0..MEM_TIMEOUT-1: the limit cycle leaves the state.
    localparam int unsigned WaitW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

    state_e             state_q, state_d;
    logic [WaitW-1:0]   wait_q, wait_d;
    logic               illegal_q, illegal_d;
    logic               timeout_q, timeout_d;
    logic               wait_limit;

    assign wait_limit    = (MEM_TIMEOUT != 0) && (wait_q == WaitW'(MEM_TIMEOUT - 1));
    assign illegal_instr = illegal_q;
    assign mem_timeout   = timeout_q;
    assign state_o       = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StReset;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        illegal_d    = illegal_q;
        timeout_d    = timeout_q;
        pc_write     = 1'b0;
        adr_src      = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        ir_write     = 1'b0;
        result_src   = 2'b00;
        alu_control  = AluAdd;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b00;
        imm_src      = 3'b000;
        reg_write    = 1'b0;
        mem_size     = 2'b00;
        mem_unsigned = 1'b0;

        case (state_q)
            StReset: state_d = StFetch;

            StFetch: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end else if (wait_limit) begin
                    timeout_d = 1'b1;
                    state_d   = StTrap;
                end
            end

            StDecode: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OpBranch:        imm_src = 3'b010;
                    OpJal:           imm_src = 3'b011;
                    OpLui, OpAuipc:  imm_src = 3'b100;
                    default:         imm_src = 3'b000;
                endcase
                case (op)
                    OpLoad:   state_d = (funct3 == 3'd3 || funct3[2:1] == 2'b11) ? StTrap
                                                                                 : StMemAdr;
                    OpStore:  state_d = (funct3 > 3'd2) ? StTrap : StMemAdr;
                    OpR:      state_d = StExecR;
                    OpI:      state_d = StExecI;
                    OpBranch: state_d = (funct3[2:1] == 2'b01) ? StTrap : StBranch;
                    OpJal:    state_d = StJal;
                    OpJalr:   state_d = StJalr;
                    OpLui:    state_d = StLui;
                    OpAuipc:  state_d = StAluWb;  // AUIPC target already computed here
                    default:  state_d = StTrap;
                endcase
                if (state_d == StTrap) illegal_d = 1'b1;
            end

            StMemAdr: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = (op == OpStore) ? 3'b001 : 3'b000;
                state_d   = (op == OpStore) ? StMemWrite : StMemRead;
            end

            StMemRead, StMemWrite: begin
                mem_req      = 1'b1;
                adr_src      = 1'b1;
                mem_size     = funct3[1:0];
                mem_we       = (state_q == StMemWrite);
                mem_unsigned = (state_q == StMemRead) && funct3[2];
                if (mem_ready) begin
                    state_d = (state_q == StMemRead) ? StMemWb : StFetch;
                end else if (wait_limit) begin
                    timeout_d = 1'b1;
                    state_d   = StTrap;
                end
            end

            StMemWb: begin
                reg_write    = 1'b1;
                result_src   = 2'b01;
                mem_size     = funct3[1:0];
                mem_unsigned = funct3[2];
                state_d      = StFetch;
            end

            StExecR, StExecI: begin
                alu_src_a = 2'b10;
                alu_src_b = (state_q == StExecI) ? 2'b01 : 2'b00;
                case (funct3)
                    3'd0:    alu_control = (state_q == StExecR && funct7_5) ? AluSub : AluAdd;
                    3'd1:    alu_control = AluSll;
                    3'd2:    alu_control = AluSlt;
                    3'd3:    alu_control = AluSltu;
                    3'd4:    alu_control = AluXor;
                    3'd5:    alu_control = funct7_5 ? AluSra : AluSrl;
                    3'd6:    alu_control = AluOr;
                    default: alu_control = AluAnd;
                endcase
                state_d = StAluWb;
            end

            StAluWb: begin
                reg_write = 1'b1;
                state_d   = StFetch;
            end

            StBranch: begin
                alu_src_a = 2'b10;
                case (funct3[2:1])
                    2'b00:   alu_control = AluSub;
                    2'b10:   alu_control = AluSlt;
                    default: alu_control = AluSltu;
                endcase
                // beq/bge/bgeu take on zero; bne/blt/bltu take on non-zero.
                pc_write = (funct3[0] ^ funct3[2]) ? ~zero : zero;
                state_d  = StFetch;
            end

            StJalr: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = StJal;
            end

            StJal: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_d   = StAluWb;
            end

            StLui: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
                imm_src   = 3'b100;
                state_d   = StAluWb;
            end

            StTrap:  state_d = StTrap;
            default: state_d = StTrap;
        endcase

        wait_d = '0;
        if (state_d == state_q && (state_q == StFetch || state_q == StMemRead ||
                                   state_q == StMemWrite) && !mem_ready) begin
            wait_d = wait_q + WaitW'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7_5, zero, mem_ready;
    logic       pc_write, adr_src, mem_req, mem_we, ir_write, reg_write, mem_unsigned;
    logic       illegal_instr, mem_timeout;
    logic [1:0] result_src, alu_src_a, alu_src_b, mem_size;
    logic [2:0] imm_src;
    logic [3:0] alu_control, state_o;

    multicycle_ctrl #(.ALU_CTRL_W(4), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
        .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write), .result_src(result_src),
        .alu_control(alu_control), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .imm_src(imm_src), .reg_write(reg_write), .mem_size(mem_size),
        .mem_unsigned(mem_unsigned), .illegal_instr(illegal_instr),
        .mem_timeout(mem_timeout), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef enum int {
        SState, SPcW, SIrW, SReq, SWe, SAdr, SRes, SAlu, SSrcA, SSrcB, SImm, SRegW,
        SSize, SUns, SIll, STo
    } sig_e;

    typedef struct {
        string      tag;
        sig_e       sig;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [7:0] obs(sig_e s);
        case (s)
            SState:  return 8'(state_o);
            SPcW:    return 8'(pc_write);
            SIrW:    return 8'(ir_write);
            SReq:    return 8'(mem_req);
            SWe:     return 8'(mem_we);
            SAdr:    return 8'(adr_src);
            SRes:    return 8'(result_src);
            SAlu:    return 8'(alu_control);
            SSrcA:   return 8'(alu_src_a);
            SSrcB:   return 8'(alu_src_b);
            SImm:    return 8'(imm_src);
            SRegW:   return 8'(reg_write);
            SSize:   return 8'(mem_size);
            SUns:    return 8'(mem_unsigned);
            SIll:    return 8'(illegal_instr);
            default: return 8'(mem_timeout);
        endcase
    endfunction

    task automatic expect_sig(string tag, sig_e s, logic [7:0] v);
        exp_t e;
        e.tag = tag;
        e.sig = s;
        e.val = v;
        sb.push_back(e);
    endtask

    // Settle combinational outputs, then drain every expectation queued for this cycle.
    task automatic chk();
        exp_t e;
        logic [7:0] got;
        #1;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            got = obs(e.sig);
            n_cmp++;
            assert (got === e.val) else begin
                n_err++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, got, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One FETCH cycle with immediate mem_ready, ending in DECODE.
    task automatic fetch_now(string tag);
        mem_ready = 1'b1;
        expect_sig({tag, "_fetch_st"}, SState, 8'd1);
        expect_sig({tag, "_fetch_irw"}, SIrW, 8'd1);
        chk();
        tick();
    endtask

    task automatic set_instr(logic [6:0] o, logic [2:0] f3, logic f7);
        op       = o;
        funct3   = f3;
        funct7_5 = f7;
    endtask

    initial begin
        reset     = 1'b1;
        op        = 7'd0;
        funct3    = 3'd0;
        funct7_5  = 1'b0;
        zero      = 1'b0;
        mem_ready = 1'b0;

        // Reset held two cycles
        tick();
        tick();
        expect_sig("rst_state", SState, 8'd0);
        expect_sig("rst_req", SReq, 8'd0);
        expect_sig("rst_pcw", SPcW, 8'd0);
        expect_sig("rst_ill", SIll, 8'd0);
        expect_sig("rst_to", STo, 8'd0);
        chk();
        reset = 1'b0;
        tick();

        // FETCH stalls three cycles, completes on the fourth
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            expect_sig("fetch_state", SState, 8'd1);
            expect_sig("fetch_req", SReq, 8'd1);
            expect_sig("fetch_srcb", SSrcB, 8'd2);
            expect_sig("fetch_res", SRes, 8'd2);
            expect_sig("fetch_irw", SIrW, (i == 3) ? 8'd1 : 8'd0);
            expect_sig("fetch_pcw", SPcW, (i == 3) ? 8'd1 : 8'd0);
            chk();
            tick();
        end

        // lw then lbu
        for (int k = 0; k < 2; k++) begin
            set_instr(7'd3, (k == 0) ? 3'd2 : 3'd4, 1'b0);
            expect_sig("ld_decode", SState, 8'd2);
            expect_sig("ld_dec_srca", SSrcA, 8'd1);
            chk();
            tick();
            expect_sig("ld_memadr", SState, 8'd3);
            expect_sig("ld_adr_srca", SSrcA, 8'd2);
            expect_sig("ld_adr_imm", SImm, 8'd0);
            chk();
            tick();
            expect_sig("ld_memread", SState, 8'd4);
            expect_sig("ld_rd_adr", SAdr, 8'd1);
            expect_sig("ld_rd_size", SSize, (k == 0) ? 8'd2 : 8'd0);
            expect_sig("ld_rd_uns", SUns, (k == 0) ? 8'd0 : 8'd1);
            chk();
            tick();
            expect_sig("ld_memwb", SState, 8'd5);
            expect_sig("ld_wb_regw", SRegW, 8'd1);
            expect_sig("ld_wb_res", SRes, 8'd1);
            expect_sig("ld_wb_size", SSize, (k == 0) ? 8'd2 : 8'd0);
            chk();
            tick();
            fetch_now("ld");
        end

        // bne with zero=0 (taken), then bgeu with zero=0 (not taken)
        for (int k = 0; k < 2; k++) begin
            set_instr(7'd99, (k == 0) ? 3'd1 : 3'd7, 1'b0);
            zero = 1'b0;
            expect_sig("br_dec_imm", SImm, 8'd2);
            chk();
            tick();
            expect_sig("br_state", SState, 8'd10);
            expect_sig("br_alu", SAlu, (k == 0) ? 8'd1 : 8'd6);
            expect_sig("br_pcw", SPcW, (k == 0) ? 8'd1 : 8'd0);
            chk();
            zero = 1'b1;
            expect_sig("br_pcw_z1", SPcW, (k == 0) ? 8'd0 : 8'd1);
            chk();
            tick();
            fetch_now("br");
        end

        // jalr: DECODE -> JALR -> JAL -> ALUWB
        set_instr(7'd103, 3'd0, 1'b0);
        tick();
        expect_sig("jalr_state", SState, 8'd12);
        expect_sig("jalr_pcw", SPcW, 8'd0);
        expect_sig("jalr_regw", SRegW, 8'd0);
        expect_sig("jalr_srcb", SSrcB, 8'd1);
        chk();
        tick();
        expect_sig("jal_state", SState, 8'd11);
        expect_sig("jal_pcw", SPcW, 8'd1);
        expect_sig("jal_regw", SRegW, 8'd0);
        chk();
        tick();
        expect_sig("jwb_state", SState, 8'd9);
        expect_sig("jwb_regw", SRegW, 8'd1);
        expect_sig("jwb_pcw", SPcW, 8'd0);
        expect_sig("jwb_res", SRes, 8'd0);
        chk();
        tick();
        fetch_now("jalr");

        // sub (R) then srai (I)
        for (int k = 0; k < 2; k++) begin
            set_instr((k == 0) ? 7'd51 : 7'd19, (k == 0) ? 3'd0 : 3'd5, 1'b1);
            tick();
            expect_sig("ex_state", SState, (k == 0) ? 8'd7 : 8'd8);
            expect_sig("ex_alu", SAlu, (k == 0) ? 8'd1 : 8'd9);
            expect_sig("ex_srcb", SSrcB, (k == 0) ? 8'd0 : 8'd1);
            chk();
            tick();
            expect_sig("ex_wb", SState, 8'd9);
            chk();
            tick();
            fetch_now("ex");
        end

        // sw with memory never ready: four MEMWRITE cycles then TRAP
        set_instr(7'd35, 3'd2, 1'b0);
        mem_ready = 1'b0;
        tick();
        expect_sig("sw_adr_imm", SImm, 8'd1);
        chk();
        tick();
        for (int i = 0; i < 4; i++) begin
            expect_sig("sw_state", SState, 8'd6);
            expect_sig("sw_we", SWe, 8'd1);
            expect_sig("sw_to", STo, 8'd0);
            chk();
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            expect_sig("to_state", SState, 8'd14);
            expect_sig("to_flag", STo, 8'd1);
            expect_sig("to_req", SReq, 8'd0);
            chk();
            tick();
        end

        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_sig("to_rst_state", SState, 8'd0);
        expect_sig("to_rst_flag", STo, 8'd0);
        chk();
        tick();
        fetch_now("ill");

        // Unknown opcode traps with illegal_instr
        set_instr(7'h7F, 3'd0, 1'b0);
        tick();
        expect_sig("ill_state", SState, 8'd14);
        expect_sig("ill_flag", SIll, 8'd1);
        expect_sig("ill_to", STo, 8'd0);
        chk();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_sig("ill_rst_state", SState, 8'd0);
        expect_sig("ill_rst_flag", SIll, 8'd0);
        chk();
        tick();
        expect_sig("ill_rst_fetch", SState, 8'd1);
        chk();
        tick();

        // Illegal load width (funct3=3) also traps
        set_instr(7'd3, 3'd3, 1'b0);
        mem_ready = 1'b1;
        tick();
        expect_sig("ldw_ill_state", SState, 8'd14);
        expect_sig("ldw_ill_flag", SIll, 8'd1);
        chk();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control FSM for the multicycle RV32I core. Decodes op/funct3/funct7_5 from the instruction register and sequences the datapath (PC, IR, ALU, register file, shared memory).
- Adds full RV32I control-flow coverage: JALR, LUI/AUIPC, all six branch conditions and byte/half/unsigned loads and stores.
- Stalls on a ready-based memory handshake with a configurable timeout.
- Traps on illegal encodings.

Parameters:
- ALU_CTRL_W, 4, width of alu_control.
- MEM_TIMEOUT, 16, maximum wait cycles per memory access before trapping; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- op  in  7  instruction opcode
- funct3  in  3  instruction funct3
- funct7_5  in  1  instruction bit 30
- zero  in  1  ALU result-is-zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  PC register load enable
- adr_src  out  1  memory address select: 0 = PC, 1 = Result
- mem_req  out  1  memory access request
- mem_we  out  1  memory write enable
- ir_write  out  1  IR and OldPC load enable
- result_src  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- alu_control  out  ALU_CTRL_W  ALU operation code
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1, 11 = zero
- alu_src_b  out  2  ALU B select: 00 = rs2, 01 = Imm, 10 = constant 4
- imm_src  out  3  immediate type: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U
- reg_write  out  1  register file write enable
- mem_size  out  2  access size: 00 = byte, 01 = half, 10 = word
- mem_unsigned  out  1  zero-extend loaded data
- illegal_instr  out  1  sticky illegal-instruction flag
- mem_timeout  out  1  sticky memory-timeout flag
- state_o  out  4  current state encoding (debug)

Behaviour:
- ALU codes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, SLL=7, SRL=8, SRA=9.
- State encodings, in order 0..14: RESET, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL, JALR, LUI, TRAP.
- Outputs are combinational from state and inputs. Any output not listed for a state is 0, with alu_control = ADD. No X values are ever driven.
- Reset:
  - Sampled high at an edge → state = RESET, wait counter = 0, both sticky flags = 0.
  - RESET drives all outputs 0 and always goes to FETCH next cycle.
  - Reset overrides any state, including a stalled access and TRAP.
- FETCH:
  - Drives mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, ADD, result_src=10.
  - Holds until mem_ready. In the mem_ready cycle only: ir_write=1, pc_write=1, then → DECODE.
- DECODE:
  - Drives alu_src_a=01, alu_src_b=01, ADD; imm_src from op (B for branch, J for jal, U for lui/auipc, else I).
  - Next state by op:
    - 3 or 35 → MEMADR
    - 51 → EXECUTER
    - 19 → EXECUTEI
    - 99 → BRANCH
    - 111 → JAL
    - 103 → JALR
    - 55 → LUI
    - 23 → ALUWB (AUIPC result already in ALUOut)
    - anything else → TRAP with illegal_instr set
  - Also TRAP with illegal_instr set on: load funct3 ∈ {3,6,7}; store funct3 > 2; branch funct3 ∈ {2,3}.
- MEMADR:
  - Drives alu_src_a=10, alu_src_b=01, ADD, imm_src = S for stores, I for loads.
  - Next: op 3 → MEMREAD, op 35 → MEMWRITE.
- MEMREAD:
  - Drives mem_req=1, adr_src=1, result_src=00, mem_size=funct3[1:0], mem_unsigned=funct3[2].
  - Waits for mem_ready, then → MEMWB.
- MEMWB: reg_write=1, result_src=01, mem_size and mem_unsigned as in MEMREAD; → FETCH.
- MEMWRITE:
  - Drives mem_req=1, mem_we=1, adr_src=1, result_src=00, mem_size=funct3[1:0].
  - Waits for mem_ready, then → FETCH.
- EXECUTER / EXECUTEI:
  - Sources: R uses alu_src_a=10, alu_src_b=00; I uses alu_src_a=10, alu_src_b=01, imm I.
  - ALU by funct3:
    - 000: SUB for R with funct7_5=1, else ADD (I is always ADD)
    - 001: SLL
    - 010: SLT
    - 011: SLTU
    - 100: XOR
    - 101: SRA if funct7_5=1, else SRL (both R and I)
    - 110: OR
    - 111: AND
  - Next → ALUWB.
- ALUWB: reg_write=1, result_src=00; → FETCH.
- BRANCH:
  - Drives alu_src_a=10, alu_src_b=00, result_src=00.
  - ALU op by funct3: SUB for beq/bne, SLT for blt/bge, SLTU for bltu/bgeu.
  - pc_write is set when the branch is taken:
    - beq, bge, bgeu: taken on zero=1
    - bne, blt, bltu: taken on zero=0
  - Next → FETCH.
- JALR: alu_src_a=10, alu_src_b=01, imm I, ADD (target into ALUOut); → JAL. Clearing bit 0 of the target is done by the datapath.
- JAL: alu_src_a=01, alu_src_b=10, ADD, result_src=00, pc_write=1; → ALUWB, which writes OldPC+4.
- LUI: alu_src_a=11, alu_src_b=01, imm U, ADD; → ALUWB.
- Wait counter:
  - Counts cycles in FETCH, MEMREAD or MEMWRITE with mem_ready=0; cleared on any state change.
  - If MEM_TIMEOUT > 0 and the count reaches MEM_TIMEOUT → TRAP with mem_timeout set.
  - mem_ready arriving in the same cycle as the limit completes the access normally.
- TRAP: all outputs 0 except the sticky flags and state_o. Held until reset.

Test Plan:
- Reset 2 cycles, then mem_ready low for 3 cycles and high on the 4th → mem_req=1 for 4 FETCH cycles; ir_write and pc_write each pulse once, in cycle 4; then DECODE.
- lw (op=3, funct3=010), mem_ready=1 → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH. MEMREAD: mem_size=10, mem_unsigned=0. MEMWB: reg_write=1, result_src=01. Repeat with lbu (funct3=100) → mem_size=00, mem_unsigned=1.
- bne (op=99, funct3=001) with zero=0 → BRANCH: alu_control=1, pc_write=1. bgeu (funct3=111) with zero=0 → alu_control=6, pc_write=0.
- jalr (op=103) → DECODE, JALR, JAL, ALUWB. pc_write=1 only in JAL; reg_write=1 only in ALUWB, with result_src=00.
- MEM_TIMEOUT=4, sw with mem_ready held 0 → after 4 MEMWRITE cycles, TRAP with mem_timeout=1, state_o=14. TRAP persists for 20 cycles.
- op=0x7F → TRAP, illegal_instr=1. Then reset for 1 cycle → state_o=0, illegal_instr=0, FETCH on the following cycle.
